// File: rtl/div_unit.sv
// Iterative restoring divider for DIV/DIVU/REM/REMU with a busy/done handshake,
// pipeline kill and a one-entry result cache for back-to-back quotient/remainder pairs.
module div_unit #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned BPC      = 1,
  parameter bit          EN_CACHE = 1'b1
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start,
  input  logic            i_kill,
  input  logic [2:0]      i_f3,
  input  logic [XLEN-1:0] i_rs1,
  input  logic [XLEN-1:0] i_rs2,
  output logic            o_busy,
  output logic            o_done,
  output logic [XLEN-1:0] o_res
);

  localparam int unsigned STEPS = XLEN / BPC;
  localparam int unsigned CW    = $clog2(STEPS + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DIV  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]      state, state_nxt;
  logic            busy_nxt, done_nxt;

  // Iteration datapath: dvd shifts the dividend out MSB-first and the quotient in LSB-first.
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] rem, dvd, dvs;
  logic [XLEN-1:0] rem_step, dvd_step;
  logic            neg_q, neg_r, want_rem;
  logic [XLEN-1:0] rs1_l, rs2_l;
  logic            uns_l;

  logic            c_vld;
  logic [XLEN-1:0] c_rs1, c_rs2, c_quo, c_rem;
  logic            c_uns;

  logic            is_signed, sgn1, sgn2;
  logic [XLEN-1:0] abs1, abs2;
  logic            div0, ovf, hit, fast, accept;
  logic [XLEN-1:0] fast_res;
  logic [XLEN-1:0] quo_fix, rem_fix;

  // Request decode and fast-path detection
  always_comb begin
    is_signed = ~i_f3[0];
    sgn1      = is_signed & i_rs1[XLEN-1];
    sgn2      = is_signed & i_rs2[XLEN-1];
    abs1      = sgn1 ? XLEN'(-i_rs1) : i_rs1;
    abs2      = sgn2 ? XLEN'(-i_rs2) : i_rs2;
    div0      = (i_rs2 == '0);
    ovf       = is_signed && (i_rs1 == MOST_NEG) && (i_rs2 == '1);
    hit       = EN_CACHE && c_vld && (i_rs1 == c_rs1) && (i_rs2 == c_rs2) &&
                (i_f3[0] == c_uns);
    fast      = div0 | ovf | hit;
    accept    = i_start && !i_kill && i_f3[2] && (state == S_IDLE);
    if (div0) begin
      fast_res = i_f3[1] ? i_rs1 : '1;
    end else if (ovf) begin
      fast_res = i_f3[1] ? '0 : MOST_NEG;
    end else begin
      fast_res = i_f3[1] ? c_rem : c_quo;
    end
  end

  // BPC restoring steps per cycle; the shifted partial remainder is XLEN+1 bits wide
  always_comb begin
    logic [XLEN-1:0] r;
    logic [XLEN-1:0] d;
    logic [XLEN:0]   r_sh;
    r = rem;
    d = dvd;
    for (int i = 0; i < int'(BPC); i++) begin
      r_sh = {r, d[XLEN-1]};
      d    = {d[XLEN-2:0], 1'b0};
      if (r_sh >= {1'b0, dvs}) begin
        r    = XLEN'(r_sh - {1'b0, dvs});
        d[0] = 1'b1;
      end else begin
        r    = r_sh[XLEN-1:0];
      end
    end
    rem_step = r;
    dvd_step = d;
  end

  // Sign correction of the unsigned result
  always_comb begin
    quo_fix = neg_q ? XLEN'(-dvd) : dvd;
    rem_fix = neg_r ? XLEN'(-rem) : rem;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept) state_nxt = fast ? S_DONE : S_DIV;
      S_DIV:  if (cnt == CW'(STEPS - 1)) state_nxt = S_FIX;
      S_FIX:  state_nxt = S_DONE;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    // A kill in the done cycle is too late; the result is already out.
    if (i_kill && (state == S_DIV || state == S_FIX)) state_nxt = S_IDLE;
    busy_nxt = (state_nxt != S_IDLE);
    done_nxt = (state_nxt == S_DONE);
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      o_busy   <= 1'b0;
      o_done   <= 1'b0;
      o_res    <= '0;
      cnt      <= '0;
      rem      <= '0;
      dvd      <= '0;
      dvs      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      want_rem <= 1'b0;
      rs1_l    <= '0;
      rs2_l    <= '0;
      uns_l    <= 1'b0;
      c_vld    <= 1'b0;
      c_rs1    <= '0;
      c_rs2    <= '0;
      c_uns    <= 1'b0;
      c_quo    <= '0;
      c_rem    <= '0;
    end else begin
      o_busy <= busy_nxt;
      o_done <= done_nxt;
      case (state)
        S_IDLE: begin
          if (accept) begin
            cnt      <= '0;
            rem      <= '0;
            dvd      <= abs1;
            dvs      <= abs2;
            neg_q    <= sgn1 ^ sgn2;
            neg_r    <= sgn1;
            want_rem <= i_f3[1];
            rs1_l    <= i_rs1;
            rs2_l    <= i_rs2;
            uns_l    <= i_f3[0];
            if (fast) o_res <= fast_res;
          end
        end
        S_DIV: begin
          rem <= rem_step;
          dvd <= dvd_step;
          cnt <= cnt + CW'(1);
        end
        S_FIX: begin
          if (!i_kill) begin
            o_res <= want_rem ? rem_fix : quo_fix;
            c_vld <= EN_CACHE;
            c_rs1 <= rs1_l;
            c_rs2 <= rs2_l;
            c_uns <= uns_l;
            c_quo <= quo_fix;
            c_rem <= rem_fix;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit: 32-bit radix-2 and 64-bit radix-4 instances.
module tb_div_unit;

  logic        clk;
  logic        rst;
  logic        start, kill;
  logic [2:0]  f3;
  logic [31:0] rs1, rs2;
  logic        busy, done;
  logic [31:0] res;

  logic        start64, kill64;
  logic [2:0]  f3_64;
  logic [63:0] rs1_64, rs2_64;
  logic        busy64, done64;
  logic [63:0] res64;

  int n_chk  = 0;
  int n_pass = 0;

  div_unit #(.XLEN(32), .BPC(1), .EN_CACHE(1'b1)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_kill(kill), .i_f3(f3),
    .i_rs1(rs1), .i_rs2(rs2), .o_busy(busy), .o_done(done), .o_res(res)
  );

  div_unit #(.XLEN(64), .BPC(2), .EN_CACHE(1'b1)) dut64 (
    .i_clk(clk), .i_rst(rst), .i_start(start64), .i_kill(kill64), .i_f3(f3_64),
    .i_rs1(rs1_64), .i_rs2(rs2_64), .o_busy(busy64), .o_done(done64), .o_res(res64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t tbl[21];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op from idle, measure latency to o_done, then check the result holds.
  task automatic run_op(input string nm, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat);
    int n;
    start = 1'b1; f3 = op; rs1 = a; rs2 = b;
    tick();
    start = 1'b0;
    chk({nm, " busy"}, 64'(busy), 64'd1);
    n = 1;
    while (!done && n < 100) begin
      tick();
      n++;
    end
    chk({nm, " lat"}, 64'(n), 64'(lat));
    chk({nm, " res"}, 64'(res), 64'(exp));
    tick();
    chk({nm, " done low"}, 64'(done), 64'd0);
    chk({nm, " hold"}, 64'(res), 64'(exp));
  endtask

  task automatic run64(input string nm, input logic [2:0] op, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] exp, input int lat);
    int n;
    start64 = 1'b1; f3_64 = op; rs1_64 = a; rs2_64 = b;
    tick();
    start64 = 1'b0;
    n = 1;
    while (!done64 && n < 100) begin
      tick();
      n++;
    end
    chk({nm, " lat"}, 64'(n), 64'(lat));
    chk({nm, " res"}, res64, exp);
    tick();
  endtask

  initial begin
    int n;
    int dcount;
    logic [31:0] last;

    tbl[0]  = '{3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34};
    tbl[1]  = '{3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 1};
    tbl[2]  = '{3'b101, 32'hFFFFFFFF, 32'd0,        32'hFFFFFFFF, 1};
    tbl[3]  = '{3'b110, 32'd5,        32'd0,        32'd5,        1};
    tbl[4]  = '{3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};
    tbl[5]  = '{3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1};
    tbl[6]  = '{3'b100, 32'd100,      32'd7,        32'd14,       34};
    tbl[7]  = '{3'b110, 32'd100,      32'd7,        32'd2,        1};
    tbl[8]  = '{3'b111, 32'd100,      32'd7,        32'd2,        34};
    tbl[9]  = '{3'b101, 32'd100,      32'd7,        32'd14,       1};
    tbl[10] = '{3'b100, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 34};
    tbl[11] = '{3'b110, 32'd7,        32'hFFFFFFFE, 32'd1,        1};
    tbl[12] = '{3'b100, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'd3,        34};
    tbl[13] = '{3'b110, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 1};
    tbl[14] = '{3'b101, 32'hFFFFFFFF, 32'd2,        32'h7FFFFFFF, 34};
    tbl[15] = '{3'b100, 32'h80000000, 32'd2,        32'hC0000000, 34};
    tbl[16] = '{3'b110, 32'h80000000, 32'd2,        32'd0,        1};
    tbl[17] = '{3'b101, 32'h80000000, 32'hFFFFFFFF, 32'd0,        34};
    tbl[18] = '{3'b111, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};
    tbl[19] = '{3'b100, 32'd0,        32'd0,        32'hFFFFFFFF, 1};
    tbl[20] = '{3'b101, 32'd5,        32'd7,        32'd0,        34};

    rst = 1'b0; start = 1'b0; kill = 1'b0; f3 = 3'b000; rs1 = '0; rs2 = '0;
    start64 = 1'b0; kill64 = 1'b0; f3_64 = 3'b000; rs1_64 = '0; rs2_64 = '0;
    tick();
    tick();
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset res", 64'(res), 64'd0);
    rst = 1'b1;
    tick();

    foreach (tbl[i]) begin
      run_op($sformatf("vec%0d", i), tbl[i].f3, tbl[i].a, tbl[i].b, tbl[i].exp, tbl[i].lat);
    end
    last = 32'd0;

    // Non-M funct3 is ignored
    start = 1'b1; f3 = 3'b000; rs1 = 32'd9; rs2 = 32'd3;
    tick();
    start = 1'b0;
    chk("ignored busy", 64'(busy), 64'd0);
    tick();
    chk("ignored done", 64'(done), 64'd0);

    // Start together with kill while idle is ignored
    start = 1'b1; kill = 1'b1; f3 = 3'b101;
    tick();
    start = 1'b0; kill = 1'b0;
    chk("start+kill busy", 64'(busy), 64'd0);

    // Kill at T+10 of DIVU 1000/3
    start = 1'b1; f3 = 3'b101; rs1 = 32'd1000; rs2 = 32'd3;
    tick();
    start = 1'b0;
    repeat (9) tick();
    kill = 1'b1;
    tick();
    kill = 1'b0;
    chk("kill busy", 64'(busy), 64'd0);
    dcount = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) dcount++;
      tick();
    end
    chk("kill no done", 64'(dcount), 64'd0);
    chk("kill res held", 64'(res), 64'(last));
    run_op("cache after kill", 3'b111, 32'd5, 32'd7, 32'd5, 1);
    run_op("divu 9/3", 3'b101, 32'd9, 32'd3, 32'd3, 34);

    // Kill in FIX: no done, no cache write
    start = 1'b1; f3 = 3'b101; rs1 = 32'd50; rs2 = 32'd5;
    tick();
    start = 1'b0;
    repeat (32) tick();
    kill = 1'b1;
    tick();
    kill = 1'b0;
    chk("fix kill busy", 64'(busy), 64'd0);
    chk("fix kill done", 64'(done), 64'd0);
    chk("fix kill res", 64'(res), 64'd3);
    run_op("after fix kill", 3'b101, 32'd50, 32'd5, 32'd10, 34);

    // Kill in the done cycle: done still pulses with the new result
    start = 1'b1; f3 = 3'b101; rs1 = 32'd20; rs2 = 32'd4;
    tick();
    start = 1'b0;
    n = 1;
    while (!done && n < 100) begin
      tick();
      n++;
    end
    chk("done kill lat", 64'(n), 64'd34);
    kill = 1'b1;
    chk("done kill res", 64'(res), 64'd5);
    tick();
    kill = 1'b0;
    chk("done kill busy", 64'(busy), 64'd0);
    chk("done kill hold", 64'(res), 64'd5);

    // Reset mid-operation, and the cache is invalidated
    run_op("cache fill", 3'b101, 32'd9, 32'd3, 32'd3, 34);
    start = 1'b1; f3 = 3'b101; rs1 = 32'd1000; rs2 = 32'd7;
    tick();
    start = 1'b0;
    repeat (4) tick();
    rst = 1'b0;
    #1;
    chk("midrst busy", 64'(busy), 64'd0);
    chk("midrst res", 64'(res), 64'd0);
    chk("midrst done", 64'(done), 64'd0);
    tick();
    rst = 1'b1;
    tick();
    chk("post rst done", 64'(done), 64'd0);
    run_op("post rst remu", 3'b111, 32'd9, 32'd3, 32'd0, 34);

    // 64-bit, two bits per cycle
    run64("u64 2^63/3", 3'b101, 64'h8000000000000000, 64'd3, 64'h2AAAAAAAAAAAAAAA, 34);
    run64("s64 -100/7", 3'b100, 64'hFFFFFFFFFFFFFF9C, 64'd7, 64'hFFFFFFFFFFFFFFF2, 34);
    run64("s64 rem -100/7", 3'b110, 64'hFFFFFFFFFFFFFF9C, 64'd7, 64'hFFFFFFFFFFFFFFFE, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
